// File: rtl/queue_rd_ctrl_pkg.sv
// Sizing constants shared by the enqueue-side and dequeue-side queue controllers.
package queue_rd_ctrl_pkg;
  localparam int QDEPTH  = 8;
  localparam int QADDR_W = 3;
  localparam int QPTR_W  = 4;
endpackage

// File: rtl/queue_rd_ctrl_ptr4_inc.sv
// 4-bit pointer incrementer: ripple of full-adder cells with b = 0 and carry-in 1.
module ptr4_inc
  import queue_rd_ctrl_pkg::*;
(
  input  logic [QPTR_W-1:0] a,
  output logic [QPTR_W-1:0] y
);
  logic [QPTR_W-1:0] c;

  assign c[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < QPTR_W; gi++) begin : g_fa
      assign y[gi] = a[gi] ^ c[gi];
      // Carry out of the top cell is the natural mod-16 wrap, so it is not built.
      if (gi < QPTR_W - 1) begin : g_carry
        assign c[gi+1] = a[gi] & c[gi];
      end
    end
  endgenerate
endmodule

// File: rtl/queue_rd_ctrl.sv
// Dequeue-side controller: read pointer, empty/count against the writer pointer,
// and a registered valid/ready output stage holding the head entry.
module queue_rd_ctrl
  import queue_rd_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [QPTR_W-1:0]  wr_ptr,
  input  logic [WIDTH-1:0]   rd_data,
  output logic [QADDR_W-1:0] rd_addr,
  output logic [QPTR_W-1:0]  rd_ptr,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic               empty,
  output logic [QPTR_W-1:0]  count,
  output logic               ovf_err
);
  logic [QPTR_W-1:0] rd_ptr_reg, rd_ptr_next, rd_ptr_inc;
  logic [WIDTH-1:0]  out_data_reg, out_data_next;
  logic              out_valid_reg, out_valid_next;
  logic              ovf_err_reg, ovf_err_next;
  logic              pop, addr_eq, wrap_eq, ovf_now;
  logic [QPTR_W-1:0] borrow_chain;

  ptr4_inc u_inc (
    .a (rd_ptr_reg),
    .y (rd_ptr_inc)
  );

  assign addr_eq = (rd_ptr_reg[QADDR_W-1:0] == wr_ptr[QADDR_W-1:0]);
  assign wrap_eq = ~(rd_ptr_reg[QPTR_W-1] ^ wr_ptr[QPTR_W-1]);
  assign empty   = addr_eq & wrap_eq;

  // count = wr_ptr + ~rd_ptr + 1, a subtract-mode adder chain, mod 16.
  assign borrow_chain[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < QPTR_W; gi++) begin : g_sub
      assign count[gi] = wr_ptr[gi] ^ ~rd_ptr_reg[gi] ^ borrow_chain[gi];
      if (gi < QPTR_W - 1) begin : g_carry
        assign borrow_chain[gi+1] = (wr_ptr[gi] & ~rd_ptr_reg[gi]) |
                                    (borrow_chain[gi] & (wr_ptr[gi] ^ ~rd_ptr_reg[gi]));
      end
    end
  endgenerate

  assign ovf_now = count[QPTR_W-1] & (|count[QADDR_W-1:0]);
  assign pop     = ~empty & (~out_valid_reg | out_ready);

  always_comb begin
    rd_ptr_next    = rd_ptr_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    ovf_err_next   = ovf_err_reg;
    if (flush) begin
      rd_ptr_next    = wr_ptr;
      out_valid_next = 1'b0;
    end else begin
      ovf_err_next = ovf_err_reg | ovf_now;
      if (pop) begin
        out_data_next  = rd_data;
        out_valid_next = 1'b1;
        rd_ptr_next    = rd_ptr_inc;
      end else if (out_valid_reg && out_ready) begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg    <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      ovf_err_reg   <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      ovf_err_reg   <= ovf_err_next;
    end
  end

  assign rd_ptr    = rd_ptr_reg;
  assign rd_addr   = rd_ptr_reg[QADDR_W-1:0];
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign ovf_err   = ovf_err_reg;
endmodule

// File: tb/tb_queue_rd_ctrl.sv
// Scoreboard bench for queue_rd_ctrl: the bench owns queue storage and the writer pointer.
module tb_queue_rd_ctrl;
  logic       clk = 1'b0;
  logic       reset, out_ready, flush;
  logic [3:0] wr_ptr;
  logic [7:0] rd_data, out_data;
  logic [2:0] rd_addr;
  logic [3:0] rd_ptr, count;
  logic       out_valid, empty, ovf_err;

  logic [7:0] mem [8];
  logic [7:0] sb_q[$];
  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;
  assign rd_data = mem[rd_addr];

  queue_rd_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .wr_ptr(wr_ptr), .rd_data(rd_data),
    .rd_addr(rd_addr), .rd_ptr(rd_ptr), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .empty(empty), .count(count), .ovf_err(ovf_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A transfer happens at the next posedge when valid && ready is seen here.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        logic [7:0] exp_v;
        exp_v = sb_q.pop_front();
        $display("xfer data=%02h exp=%02h", out_data, exp_v);
        check("xfer_data", {24'd0, out_data}, {24'd0, exp_v});
      end
      xfer_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [7:0] v);
    mem[wr_ptr[2:0]] = v;
    wr_ptr = wr_ptr + 4'd1;
    sb_q.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_ptr = 4'd0;
    sb_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] prev_ptr;
    logic seen_7_8, seen_15_0;
    int x0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_ptr = 4'd0;
    #1;
    do_reset();
    mon_en = 1'b1;

    // Reset state
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rd_ptr", {28'd0, rd_ptr}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, ovf_err}, 32'd0);

    // Three entries streamed with ready held high
    out_ready = 1'b1;
    x0 = xfer_cnt;
    write_entry(8'hA1);
    tick();
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_data", {24'd0, out_data}, 32'hA1);
    write_entry(8'hB2);
    tick();
    write_entry(8'hC3);
    repeat (4) tick();
    check("s3_xfers", xfer_cnt - x0, 32'd3);
    check("s3_rd_ptr", {28'd0, rd_ptr}, 32'd3);
    check("s3_empty", {31'd0, empty}, 32'd1);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_entry(8'h10 + 8'(i));
      tick();
    end
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_data", {24'd0, out_data}, 32'h10);
    check("bp_count", {28'd0, count}, 32'd4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_stable", {23'd0, out_valid, out_data}, 32'h110);
    end
    x0 = xfer_cnt;
    out_ready = 1'b1;
    repeat (5) tick();
    check("bp_xfers", xfer_cnt - x0, 32'd5);
    check("bp_drained", {30'd0, out_valid, empty}, 32'd1);

    // Wrap-around: 20 entries from pointer 0
    do_reset();
    out_ready = 1'b1;
    seen_7_8 = 1'b0; seen_15_0 = 1'b0;
    x0 = xfer_cnt;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) write_entry(8'(i));
      prev_ptr = rd_ptr;
      tick();
      if (prev_ptr == 4'd7 && rd_ptr == 4'd8) begin
        seen_7_8 = 1'b1;
        check("wrap_addr8", {29'd0, rd_addr}, 32'd0);
      end
      if (prev_ptr == 4'd15 && rd_ptr == 4'd0) seen_15_0 = 1'b1;
    end
    check("wrap_7_8", {31'd0, seen_7_8}, 32'd1);
    check("wrap_15_0", {31'd0, seen_15_0}, 32'd1);
    check("wrap_xfers", xfer_cnt - x0, 32'd20);
    check("wrap_rd_ptr", {28'd0, rd_ptr}, 32'd4);

    // Full queue and overflow
    mon_en = 1'b0;
    do_reset();
    out_ready = 1'b0;
    wr_ptr = 4'd8;
    #1;
    check("full_count", {28'd0, count}, 32'd8);
    check("full_empty", {31'd0, empty}, 32'd0);
    check("full_ovf", {31'd0, ovf_err}, 32'd0);
    wr_ptr = 4'd9;
    #1;
    check("ovf_count", {28'd0, count}, 32'd9);
    tick();
    check("ovf_set", {31'd0, ovf_err}, 32'd1);
    wr_ptr = rd_ptr;
    repeat (5) tick();
    check("ovf_sticky", {31'd0, ovf_err}, 32'd1);
    do_reset();
    check("ovf_clear", {31'd0, ovf_err}, 32'd0);

    // Flush with a held entry and four queued
    mon_en = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_entry(8'h30 + 8'(i));
      tick();
    end
    check("fl_pre_count", {28'd0, count}, 32'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb_q.delete();
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_rd_ptr", {28'd0, rd_ptr}, {28'd0, wr_ptr});
    check("fl_empty", {31'd0, empty}, 32'd1);
    check("fl_data_kept", {24'd0, out_data}, 32'h30);

    // Write landing on the flush edge survives
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb_q.delete();
    write_entry(8'h5A);
    out_ready = 1'b1;
    x0 = xfer_cnt;
    repeat (3) tick();
    check("fl_survive", xfer_cnt - x0, 32'd1);

    // Reset and flush together
    out_ready = 1'b0;
    write_entry(8'h77);
    write_entry(8'h78);
    repeat (2) tick();
    reset = 1'b1;
    flush = 1'b1;
    wr_ptr = 4'd0;
    sb_q.delete();
    tick();
    reset = 1'b0;
    flush = 1'b0;
    check("rf_rd_ptr", {28'd0, rd_ptr}, 32'd0);
    check("rf_valid", {31'd0, out_valid}, 32'd0);
    check("rf_data", {24'd0, out_data}, 32'd0);
    check("rf_ovf", {31'd0, ovf_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
